// File: rtl/hazard_pipe_tracker.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pipe_tracker
// Description : Tracks the control bits of each instruction as it moves from
//               ID through EXE, MEM and WB. Hazard stalls insert bubbles into
//               EXE while older instructions keep draining. Saturating
//               counters record retired instructions, load-use stall cycles
//               and branch bubble cycles.
//
// Ports
//   clk                 : rising-edge clock
//   rst                 : asynchronous active-high reset
//   id_*_i              : decoded control bits and destination of the ID slot
//   stall_i             : hazard stall request from decode control
//   remain_pc_i         : 1 = load-use stall, 0 = branch bubble
//   cnt_clr_i           : synchronous clear for all counters
//   exe_*_o / mem_*_o / wb_*_o : per-stage control bits and destinations
//   cnt_retired_o       : valid instructions leaving WB (32 bit, saturating)
//   cnt_load_stall_o    : load-use stall cycles (16 bit, saturating)
//   cnt_branch_bubble_o : branch bubble cycles (16 bit, saturating)
//
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_pipe_tracker (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid_i,
    input  logic        id_wreg_i,
    input  logic        id_mem2reg_i,
    input  logic        id_wmem_i,
    input  logic        id_jal_i,
    input  logic [4:0]  id_regw_addr_i,
    input  logic        stall_i,
    input  logic        remain_pc_i,
    input  logic        cnt_clr_i,
    output logic        exe_valid_o,
    output logic        exe_wreg_o,
    output logic        exe_mem2reg_o,
    output logic        exe_wmem_o,
    output logic        exe_jal_o,
    output logic [4:0]  exe_regw_addr_o,
    output logic        mem_valid_o,
    output logic        mem_wreg_o,
    output logic        mem_mem2reg_o,
    output logic        mem_wmem_o,
    output logic [4:0]  mem_regw_addr_o,
    output logic        wb_valid_o,
    output logic        wb_wreg_o,
    output logic        wb_mem2reg_o,
    output logic [4:0]  wb_regw_addr_o,
    output logic [31:0] cnt_retired_o,
    output logic [15:0] cnt_load_stall_o,
    output logic [15:0] cnt_branch_bubble_o
);

    localparam int ADDR_W = 5;
    localparam int RET_W  = 32;
    localparam int EVT_W  = 16;

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic              exe_valid_q, exe_wreg_q, exe_mem2reg_q, exe_wmem_q, exe_jal_q;
    logic [ADDR_W-1:0] exe_addr_q;
    logic              exe_valid_d, exe_wreg_d, exe_mem2reg_d, exe_wmem_d, exe_jal_d;
    logic [ADDR_W-1:0] exe_addr_d;

    logic              mem_valid_q, mem_wreg_q, mem_mem2reg_q, mem_wmem_q;
    logic [ADDR_W-1:0] mem_addr_q;

    logic              wb_valid_q, wb_wreg_q, wb_mem2reg_q;
    logic [ADDR_W-1:0] wb_addr_q;

    logic [RET_W-1:0]  cnt_ret_q, cnt_ret_d;
    logic [EVT_W-1:0]  cnt_ld_q,  cnt_ld_d;
    logic [EVT_W-1:0]  cnt_br_q,  cnt_br_d;

    logic w_bubble;
    logic w_load_stall;
    logic w_branch_bubble;

    assign w_bubble        = stall_i | ~id_valid_i;
    assign w_load_stall    = stall_i & remain_pc_i;
    assign w_branch_bubble = stall_i & ~remain_pc_i;

    // EXE capture: a bubble clears every control bit and the destination.
    // Writes to $0 are dropped here so later stages never see them, while
    // jal still marks the slot as a link instruction.
    always_comb begin
        exe_valid_d   = 1'b0;
        exe_wreg_d    = 1'b0;
        exe_mem2reg_d = 1'b0;
        exe_wmem_d    = 1'b0;
        exe_jal_d     = 1'b0;
        exe_addr_d    = '0;
        if (!w_bubble) begin
            exe_valid_d   = 1'b1;
            exe_wreg_d    = id_wreg_i & (id_regw_addr_i != '0);
            exe_mem2reg_d = id_mem2reg_i;
            exe_wmem_d    = id_wmem_i;
            exe_jal_d     = id_jal_i;
            exe_addr_d    = id_regw_addr_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_valid_q   <= 1'b0;
            exe_wreg_q    <= 1'b0;
            exe_mem2reg_q <= 1'b0;
            exe_wmem_q    <= 1'b0;
            exe_jal_q     <= 1'b0;
            exe_addr_q    <= '0;
            mem_valid_q   <= 1'b0;
            mem_wreg_q    <= 1'b0;
            mem_mem2reg_q <= 1'b0;
            mem_wmem_q    <= 1'b0;
            mem_addr_q    <= '0;
            wb_valid_q    <= 1'b0;
            wb_wreg_q     <= 1'b0;
            wb_mem2reg_q  <= 1'b0;
            wb_addr_q     <= '0;
        end else begin
            exe_valid_q   <= exe_valid_d;
            exe_wreg_q    <= exe_wreg_d;
            exe_mem2reg_q <= exe_mem2reg_d;
            exe_wmem_q    <= exe_wmem_d;
            exe_jal_q     <= exe_jal_d;
            exe_addr_q    <= exe_addr_d;
            // jal is resolved in EXE and is not carried further.
            mem_valid_q   <= exe_valid_q;
            mem_wreg_q    <= exe_wreg_q;
            mem_mem2reg_q <= exe_mem2reg_q;
            mem_wmem_q    <= exe_wmem_q;
            mem_addr_q    <= exe_addr_q;
            // Stores complete in MEM; WB only needs the write-back controls.
            wb_valid_q    <= mem_valid_q;
            wb_wreg_q     <= mem_wreg_q;
            wb_mem2reg_q  <= mem_mem2reg_q;
            wb_addr_q     <= mem_addr_q;
        end
    end

    // ------------------------------------------------------------------
    // Saturating event counters; clear wins over a same-cycle increment.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_ret_d = cnt_ret_q;
        cnt_ld_d  = cnt_ld_q;
        cnt_br_d  = cnt_br_q;
        if (cnt_clr_i) begin
            cnt_ret_d = '0;
            cnt_ld_d  = '0;
            cnt_br_d  = '0;
        end else begin
            if (wb_valid_q && (cnt_ret_q != '1)) begin
                cnt_ret_d = cnt_ret_q + 1'b1;
            end
            if (w_load_stall && (cnt_ld_q != '1)) begin
                cnt_ld_d = cnt_ld_q + 1'b1;
            end
            if (w_branch_bubble && (cnt_br_q != '1)) begin
                cnt_br_d = cnt_br_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_ret_q <= '0;
            cnt_ld_q  <= '0;
            cnt_br_q  <= '0;
        end else begin
            cnt_ret_q <= cnt_ret_d;
            cnt_ld_q  <= cnt_ld_d;
            cnt_br_q  <= cnt_br_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign exe_valid_o         = exe_valid_q;
    assign exe_wreg_o          = exe_wreg_q;
    assign exe_mem2reg_o       = exe_mem2reg_q;
    assign exe_wmem_o          = exe_wmem_q;
    assign exe_jal_o           = exe_jal_q;
    assign exe_regw_addr_o     = exe_addr_q;
    assign mem_valid_o         = mem_valid_q;
    assign mem_wreg_o          = mem_wreg_q;
    assign mem_mem2reg_o       = mem_mem2reg_q;
    assign mem_wmem_o          = mem_wmem_q;
    assign mem_regw_addr_o     = mem_addr_q;
    assign wb_valid_o          = wb_valid_q;
    assign wb_wreg_o           = wb_wreg_q;
    assign wb_mem2reg_o        = wb_mem2reg_q;
    assign wb_regw_addr_o      = wb_addr_q;
    assign cnt_retired_o       = cnt_ret_q;
    assign cnt_load_stall_o    = cnt_ld_q;
    assign cnt_branch_bubble_o = cnt_br_q;

endmodule
`default_nettype wire

// File: doc/hazard_pipe_tracker.md
HAZARD_PIPE_TRACKER -- requirements
Module: hazard_pipe_tracker

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: `clk input 1 rising-edge clock`.
REQ-002 `rst input 1` SHALL be the asynchronous, active-high reset.
REQ-003 `id_valid input 1` SHALL mark a real instruction in ID (0 = empty slot).
REQ-004 `id_wreg input 1` SHALL be the decoded register-write enable.
REQ-005 `id_mem2reg input 1` SHALL be the decoded load (write-back from memory).
REQ-006 `id_wmem input 1` SHALL be the decoded store.
REQ-007 `id_jal input 1` SHALL be the decoded link-write (jal).
REQ-008 `id_regw_addr input 5` SHALL be the destination register, already muxed rd/rt/31.
REQ-009 `stall input 1` SHALL be the hazard stall request from decode control.
REQ-010 `remain_pc input 1` SHALL be 1 for a load-use stall and 0 for a branch bubble.
REQ-011 `cnt_clr input 1` SHALL be the synchronous clear for all counters.
REQ-012 `exe_valid, exe_wreg, exe_mem2reg, exe_wmem, exe_jal output 1 each` SHALL be the EXE-stage control bits.
REQ-013 `exe_regw_addr output 5` SHALL be the EXE destination register.
REQ-014 `mem_valid, mem_wreg, mem_mem2reg, mem_wmem output 1 each` SHALL be the MEM-stage control bits.
REQ-015 `mem_regw_addr output 5` SHALL be the MEM destination register.
REQ-016 `wb_valid, wb_wreg, wb_mem2reg output 1 each` SHALL be the WB-stage control bits.
REQ-017 `wb_regw_addr output 5` SHALL be the WB destination register.
REQ-018 `cnt_retired output 32` SHALL count valid instructions leaving WB.
REQ-019 `cnt_load_stall output 16` SHALL count load-use stall cycles.
REQ-020 `cnt_branch_bubble output 16` SHALL count branch bubble cycles.

Function
REQ-021 Stage registers SHALL advance every rising clk edge; there is no global enable.
REQ-022 EXE SHALL load a bubble when stall=1 or id_valid=0.
- Bubble = all EXE control bits 0, exe_regw_addr=0.
- Otherwise EXE SHALL load the id_* fields with exe_valid=1.
REQ-023 When id_regw_addr=0, exe_wreg SHALL be captured as 0 and exe_jal SHALL be unaffected.
REQ-024 MEM SHALL load EXE unconditionally each cycle; exe_jal SHALL NOT propagate.
REQ-025 WB SHALL load MEM unconditionally each cycle; mem_wmem SHALL NOT propagate.
REQ-026 ID-to-output latency SHALL be 1 cycle to EXE, 2 cycles to MEM and 3 cycles to WB.
REQ-027 A stall SHALL NOT freeze EXE, MEM or WB; older instructions SHALL continue to drain.
REQ-028 cnt_load_stall SHALL increment on a cycle with stall=1 and remain_pc=1.
REQ-029 cnt_branch_bubble SHALL increment on a cycle with stall=1 and remain_pc=0.
REQ-030 cnt_retired SHALL increment on a cycle with wb_valid=1.
REQ-031 All counters SHALL saturate at all-ones (no wrap).
REQ-032 cnt_clr=1 SHALL zero all counters on that edge, overriding a same-cycle increment; stage registers are unaffected.
REQ-033 remain_pc=1 with stall=0 SHALL be ignored: no bubble and no count.

Reset
REQ-034 rst=1 SHALL asynchronously clear every stage register and counter to 0, so all outputs read 0.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight instructions with no retire count.
REQ-036 The first edge after rst deasserts SHALL capture ID normally.

Verification
REQ-037 Load-use stall:
- Stimulus: lw to r5, then one cycle with stall=1, remain_pc=1.
- Required: exe_mem2reg=1 and exe_regw_addr=5 at T+1; exe_valid=0 at T+2; cnt_load_stall=1; mem_regw_addr=5 at T+2.
REQ-038 Register $0 suppression:
- Stimulus: add with id_regw_addr=0, id_wreg=1.
- Required: exe_wreg=0 and exe_valid=1; the slot reaches WB with wb_wreg=0; cnt_retired increments.
REQ-039 Counter saturation:
- Stimulus: force 70000 branch bubbles (stall=1, remain_pc=0).
- Required: cnt_branch_bubble holds at 16'hFFFF.
- Then: cnt_clr=1 on the same cycle as stall=1 gives 0.
REQ-040 Mid-operation reset:
- Stimulus: 3 valid instructions in flight, then rst pulsed asynchronously between edges.
- Required: all outputs read 0 immediately; cnt_retired=0 after release.
REQ-041 Back-to-back pipe:
- Stimulus: 10 consecutive valid instructions with no stall.
- Required: wb_regw_addr sequence matches the inputs delayed by 3 cycles; cnt_retired=10.
REQ-042 Ignored remain_pc:
- Stimulus: remain_pc=1 with stall=0.
- Required: EXE captures the instruction; cnt_load_stall is unchanged.
